ap_host_seq: RTL and testbench
==============================

Name: ap_host_seq

Overview:
- Host-side sequencer that sits directly upstream of the associative processor (AP_s) and drives its memory/command port.
- Loads operand columns A and B from an input word stream.
- Launches one AP command, waits for ap_state_irq, then streams column C back out.
- Replaces hand-written bench/CPU poking of the AP port with one start/done job interface.

Parameters:
- WORD_SIZE, 8, width of one cell word.
- CELL_QUANT, 512, number of AP cells.
- ADDR_W, 10, AP address width; equals clogb2(CELL_QUANT) using the codebase's clogb2.
- RD_LAT, 1, cycles from ap_read_en to valid ap_data_out; legal range 1..3.
- TIMEOUT, 4096, maximum cycles to wait for ap_state_irq.

Ports:
- CLK100MHZ  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- start  in  1  one-cycle job request; ignored while busy=1.
- op  in  3  AP command, captured at start.
- n_words  in  ADDR_W  cells per column, captured at start; 0 = empty job.
- s_valid  in  1  input stream valid.
- s_data  in  WORD_SIZE  input word.
- s_ready  out  1  input stream ready.
- m_valid  out  1  result stream valid.
- m_data  out  WORD_SIZE  column C word.
- m_ready  in  1  result stream ready.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- ap_addr  out  ADDR_W  to AP addr_in.
- ap_data  out  WORD_SIZE  to AP data_in.
- ap_sel_col  out  2  0 = col A, 1 = col B, 2 = col C.
- ap_write_en  out  1  to AP write_en.
- ap_read_en  out  1  to AP read_en.
- ap_mode  out  1  to AP ap_mode.
- ap_cmd  out  3  to AP cmd.
- ap_data_out  in  WORD_SIZE  from AP data_out.
- ap_state_irq  in  1  from AP; high = command complete.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, counters 0.
  - Reset mid-job aborts immediately; no done pulse.
  - The AP port is left quiescent: write_en, read_en and ap_mode all 0.
- All outputs are registered.
- FSM states: IDLE, LOAD_A, LOAD_B, RUN, READ_REQ, READ_WAIT, READ_OUT, FIN.
- IDLE, start=1:
  - Latch op and n_words; clear err; busy=1.
  - n_words=0 -> go to FIN; otherwise -> LOAD_A with cell index i=0.
- LOAD_A:
  - s_ready=1.
  - On each s_valid&&s_ready, next cycle drives ap_write_en=1, ap_sel_col=0, ap_addr=i, ap_data=s_data for exactly one cycle; i++.
  - After n_words accepted -> LOAD_B with i=0. s_ready drops the cycle after the last word is accepted.
- LOAD_B: identical to LOAD_A with ap_sel_col=1; then -> RUN.
- RUN:
  - ap_cmd=op, ap_mode=1; both held stable for the whole state. Timeout counter starts at 0.
  - ap_state_irq=1 sampled -> ap_mode=0 next cycle, go to READ_REQ with i=0.
  - Counter reaches TIMEOUT-1 with no irq -> ap_mode=0, err=1, go to FIN (no readback).
  - An irq arriving in any state other than RUN is ignored.
- READ_REQ: one cycle of ap_read_en=1, ap_sel_col=2, ap_addr=i -> READ_WAIT.
- READ_WAIT: wait RD_LAT cycles, capture ap_data_out into m_data, m_valid=1 -> READ_OUT.
- READ_OUT:
  - Hold m_valid and m_data stable until m_ready.
  - On handshake: m_valid=0, i++. If i==n_words -> FIN, else -> READ_REQ.
  - Throughput is one word per RD_LAT+2 cycles when m_ready=1.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
  - start in the FIN cycle is ignored; start is accepted from the next cycle.
- Index wrap: n_words values above CELL_QUANT are clamped to CELL_QUANT.
- ap_write_en and ap_read_en are never high in the same cycle; ap_mode is never high while either is high.

Test Plan:
- Reset: hold rst=0 for 5 cycles with start=1 -> all outputs 0, busy=0. Release rst -> outputs unchanged until the next start.
- Basic job: n_words=4, op=3, stream A={1,2,3,4}, B={5,6,7,8}.
  - Writes go to A addr0..3, then B addr0..3.
  - ap_mode=1 with ap_cmd=3 until irq is asserted 20 cycles later.
  - Reads C addr0..3; m_data equals the AP model's C values in order.
  - done pulses once; err=0.
- Backpressure: same job with m_ready toggling 1,0,0,1 and s_valid gaps of 2 cycles.
  - m_data is held stable while m_valid&&!m_ready; no word is lost or duplicated.
  - Exactly 8 writes occur.
- Timeout: TIMEOUT=16, irq never asserted -> ap_mode falls after 16 RUN cycles, err=1, done pulses, no ap_read_en.
  - Next start clears err.
- Empty and ignored starts:
  - n_words=0 -> busy for 1 cycle then done; no AP traffic.
  - A start pulse issued mid-LOAD_B is ignored and the op is unchanged.
- Abort: assert rst during RUN -> ap_mode=0 asynchronously, no done.
  - A fresh job with n_words=2 then completes correctly.

Source files
------------

// File: rtl/ap_host_seq.sv
// Host-side job sequencer for the associative processor: streams operand
// columns A and B into the AP, launches one command, waits for completion
// and streams column C back out over a valid/ready interface.
module ap_host_seq #(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512,
   parameter int ADDR_W     = 10,
   parameter int RD_LAT     = 1,
   parameter int TIMEOUT    = 4096
) (
   input  logic                 CLK100MHZ,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [ADDR_W-1:0]    n_words,
   input  logic                 s_valid,
   input  logic [WORD_SIZE-1:0] s_data,
   output logic                 s_ready,
   output logic                 m_valid,
   output logic [WORD_SIZE-1:0] m_data,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ADDR_W-1:0]    ap_addr,
   output logic [WORD_SIZE-1:0] ap_data,
   output logic [1:0]           ap_sel_col,
   output logic                 ap_write_en,
   output logic                 ap_read_en,
   output logic                 ap_mode,
   output logic [2:0]           ap_cmd,
   input  logic [WORD_SIZE-1:0] ap_data_out,
   input  logic                 ap_state_irq
);

   localparam int                TMO_W    = $clog2(TIMEOUT) + 1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] CQ       = ADDR_W'(CELL_QUANT);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, RUN, READ_REQ, READ_WAIT, READ_OUT, FIN
   } state_t;

   // Job lengths beyond the cell array saturate to the array size.
   function automatic logic [ADDR_W-1:0] clamp_n(input logic [ADDR_W-1:0] n);
      return (n > CQ) ? CQ : n;
   endfunction

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [ADDR_W-1:0]    n_q, n_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [1:0]           lat_q, lat_d;
   logic                 s_ready_q, s_ready_d;
   logic                 m_valid_q, m_valid_d;
   logic [WORD_SIZE-1:0] m_data_q, m_data_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [WORD_SIZE-1:0] data_q, data_d;
   logic [1:0]           sel_q, sel_d;
   logic                 we_q, we_d;
   logic                 re_q, re_d;
   logic                 mode_q, mode_d;
   logic [2:0]           cmd_q, cmd_d;

   // State and registered outputs; reset leaves the AP port quiescent.
   always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         tmo_q     <= '0;
         lat_q     <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         mode_q    <= 1'b0;
         cmd_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         lat_q     <= lat_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         re_q      <= re_d;
         mode_q    <= mode_d;
         cmd_q     <= cmd_d;
      end
   end

   // Next-state and next-output logic for the job sequence.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      n_d       = n_q;
      idx_d     = idx_q;
      tmo_d     = tmo_q;
      lat_d     = lat_q;
      s_ready_d = s_ready_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      addr_d    = addr_q;
      data_d    = data_q;
      sel_d     = sel_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      mode_d    = mode_q;
      cmd_d     = cmd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d   = op;
               n_d    = clamp_n(n_words);
               err_d  = 1'b0;
               busy_d = 1'b1;
               idx_d  = '0;
               if (clamp_n(n_words) == '0) begin
                  state_d = FIN;
               end else begin
                  state_d   = LOAD_A;
                  s_ready_d = 1'b1;
               end
            end
         end
         LOAD_A, LOAD_B: begin
            // s_ready takes a one-cycle bubble between the two columns
            s_ready_d = 1'b1;
            if (s_valid && s_ready_q) begin
               we_d   = 1'b1;
               sel_d  = (state_q == LOAD_B) ? 2'd1 : 2'd0;
               addr_d = idx_q;
               data_d = s_data;
               if (idx_q == n_q - ONE) begin
                  idx_d     = '0;
                  s_ready_d = 1'b0;
                  tmo_d     = '0;
                  state_d   = (state_q == LOAD_A) ? LOAD_B : RUN;
               end else begin
                  idx_d = idx_q + ONE;
               end
            end
         end
         RUN: begin
            // ap_mode rises one cycle in so it never overlaps the last B write
            mode_d = 1'b1;
            cmd_d  = op_q;
            if (mode_q && ap_state_irq) begin
               mode_d  = 1'b0;
               idx_d   = '0;
               re_d    = 1'b1;
               sel_d   = 2'd2;
               addr_d  = '0;
               state_d = READ_REQ;
            end else if (mode_q && (tmo_q == TMO_LAST)) begin
               mode_d  = 1'b0;
               err_d   = 1'b1;
               state_d = FIN;
            end else if (mode_q) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         READ_REQ: begin
            lat_d   = '0;
            state_d = READ_WAIT;
         end
         READ_WAIT: begin
            if (lat_q == LAT_LAST) begin
               m_data_d  = ap_data_out;
               m_valid_d = 1'b1;
               state_d   = READ_OUT;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         READ_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (idx_q == n_q - ONE) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q + ONE;
                  re_d    = 1'b1;
                  sel_d   = 2'd2;
                  addr_d  = idx_q + ONE;
                  state_d = READ_REQ;
               end
            end
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign s_ready     = s_ready_q;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign ap_addr     = addr_q;
   assign ap_data     = data_q;
   assign ap_sel_col  = sel_q;
   assign ap_write_en = we_q;
   assign ap_read_en  = re_q;
   assign ap_mode     = mode_q;
   assign ap_cmd      = cmd_q;

endmodule

// File: tb/tb_ap_host_seq.sv
// Bench for ap_host_seq: behavioural AP model, stream drivers and a
// scoreboard of expected AP writes and expected result words.
module tb_ap_host_seq;

   logic       clk = 1'b0;
   logic       rst, start, s_valid, m_ready;
   logic [2:0] op;
   logic [9:0] n_words;
   logic [7:0] s_data;

   logic       s_ready, m_valid, busy, done, err, ap_write_en, ap_read_en, ap_mode;
   logic [7:0] m_data, ap_data, ap_data_out;
   logic [9:0] ap_addr;
   logic [1:0] ap_sel_col;
   logic [2:0] ap_cmd;
   logic       irq;

   logic       t_s_ready, t_m_valid, t_busy, t_done, t_err, t_we, t_re, t_mode;
   logic [7:0] t_m_data, t_ap_data;
   logic [7:0] t_ap_data_out = 8'd0;
   logic [9:0] t_ap_addr;
   logic [1:0] t_sel;
   logic [2:0] t_cmd;
   logic       t_irq = 1'b0;

   int n_chk = 0, n_err = 0;
   int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, mode_cyc = 0, cmd_bad = 0;
   int hold_bad = 0, excl_bad = 0, t_done_cnt = 0, t_mode_cyc = 0, t_rd_cnt = 0;
   logic [2:0]  cur_op = 3'd0;
   logic        irq_en = 1'b1;
   logic        bp_mode = 1'b0;
   logic [0:3]  bp_pat = 4'b1001;
   logic [19:0] exp_wr[$];
   logic [7:0]  exp_m[$];
   logic [7:0]  wa[0:3], wb[0:3];

   always #5 clk = ~clk;

   ap_host_seq dut (
      .CLK100MHZ(clk), .rst(rst), .start(start), .op(op), .n_words(n_words),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .busy(busy), .done(done), .err(err),
      .ap_addr(ap_addr), .ap_data(ap_data), .ap_sel_col(ap_sel_col),
      .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_mode(ap_mode),
      .ap_cmd(ap_cmd), .ap_data_out(ap_data_out), .ap_state_irq(irq)
   );

   ap_host_seq #(.TIMEOUT(16)) dut_t (
      .CLK100MHZ(clk), .rst(rst), .start(start), .op(op), .n_words(n_words),
      .s_valid(s_valid), .s_data(s_data), .s_ready(t_s_ready),
      .m_valid(t_m_valid), .m_data(t_m_data), .m_ready(m_ready),
      .busy(t_busy), .done(t_done), .err(t_err),
      .ap_addr(t_ap_addr), .ap_data(t_ap_data), .ap_sel_col(t_sel),
      .ap_write_en(t_we), .ap_read_en(t_re), .ap_mode(t_mode),
      .ap_cmd(t_cmd), .ap_data_out(t_ap_data_out), .ap_state_irq(t_irq)
   );

   function automatic logic [7:0] ap_func(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
      return (c == 3'd3) ? a + b : a ^ b;
   endfunction

   // AP model: column memories, command computes C, irq 20 cycles after ap_mode rises
   logic [7:0] mem_a[0:1023], mem_b[0:1023], mem_c[0:1023];
   logic       mode_seen;
   int         irq_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq <= 1'b0; irq_cnt <= 0; mode_seen <= 1'b0; ap_data_out <= 8'd0;
      end else begin
         if (ap_write_en && ap_sel_col == 2'd0) mem_a[ap_addr] <= ap_data;
         if (ap_write_en && ap_sel_col == 2'd1) mem_b[ap_addr] <= ap_data;
         if (ap_read_en) ap_data_out <= mem_c[ap_addr];
         if (ap_mode) begin
            irq_cnt   <= irq_cnt + 1;
            irq       <= irq_en && (irq_cnt >= 19);
            mode_seen <= 1'b1;
            if (!mode_seen)
               for (int k = 0; k < 1024; k++) mem_c[k] <= ap_func(ap_cmd, mem_a[k], mem_b[k]);
         end else begin
            irq_cnt <= 0; irq <= 1'b0; mode_seen <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // m_ready: constant 1, or the 1,0,0,1 backpressure pattern
   initial begin
      int k;
      k = 0; m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin m_ready = bp_pat[k]; k = (k + 1) % 4; end
         else m_ready = 1'b1;
      end
   end

   // Output monitor and scoreboard, sampled on the falling edge
   initial begin
      logic       held;
      logic [7:0] held_d;
      held = 1'b0; held_d = 8'd0;
      forever begin
         @(negedge clk);
         if (held && (!m_valid || m_data !== held_d)) hold_bad++;
         held = m_valid && !m_ready;
         held_d = m_data;
         if (ap_write_en) begin
            wr_cnt++;
            if (exp_wr.size() == 0) chk("wr_extra", 32'(exp_wr.size()), 1);
            else chk("ap_write", {12'd0, ap_sel_col, ap_addr, ap_data}, {12'd0, exp_wr.pop_front()});
         end
         if (m_valid && m_ready) begin
            if (exp_m.size() == 0) chk("m_extra", 32'(exp_m.size()), 1);
            else chk("m_data", {24'd0, m_data}, {24'd0, exp_m.pop_front()});
         end
         if ((ap_write_en && ap_read_en) || (ap_mode && (ap_write_en || ap_read_en))) excl_bad++;
         if ((t_we && t_re) || (t_mode && (t_we || t_re))) excl_bad++;
         if (ap_mode) begin mode_cyc++; if (ap_cmd !== cur_op) cmd_bad++; end
         if (ap_read_en) rd_cnt++;
         if (done) done_cnt++;
         if (t_mode) t_mode_cyc++;
         if (t_re) t_rd_cnt++;
         if (t_done) t_done_cnt++;
      end
   end

   task automatic clear_counts();
      wr_cnt = 0; rd_cnt = 0; done_cnt = 0; mode_cyc = 0; cmd_bad = 0;
      hold_bad = 0; excl_bad = 0; t_done_cnt = 0; t_mode_cyc = 0; t_rd_cnt = 0;
   endtask

   task automatic send_word(input logic [7:0] d, input int gap);
      logic acc;
      int   c;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = d; acc = 1'b0; c = 0;
      while (!acc && c < 100) begin
         @(negedge clk); acc = s_ready;
         @(posedge clk); #1; c++;
      end
      s_valid = 1'b0;
      chk("s_accept", {31'd0, acc}, 1);
   endtask

   task automatic launch_job(input logic [2:0] o, input int n, input int gap, input int inj, input logic want_c);
      clear_counts();
      cur_op = o; op = o; n_words = 10'(n); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int j = 0; j < n; j++) begin
         exp_wr.push_back({2'd0, 10'(j), wa[j]});
         send_word(wa[j], gap);
      end
      for (int j = 0; j < n; j++) begin
         if (j == inj) begin
            start = 1'b1; op = 3'd6; n_words = 10'd7;
            @(posedge clk); #1; start = 1'b0; op = o;
         end
         exp_wr.push_back({2'd1, 10'(j), wb[j]});
         if (want_c) exp_m.push_back(ap_func(o, wa[j], wb[j]));
         send_word(wb[j], gap);
      end
   endtask

   task automatic wait_done(input int maxc);
      int c;
      c = 0;
      while (done_cnt == 0 && c < maxc) begin @(posedge clk); c++; end
      chk("done_seen", (done_cnt != 0) ? 32'd1 : 32'd0, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic job_checks(input int n);
      chk("wr_cnt", wr_cnt, 2 * n);
      chk("rd_cnt", rd_cnt, n);
      chk("done_cnt", done_cnt, 1);
      chk("err", {31'd0, err}, 0);
      chk("busy_end", {31'd0, busy}, 0);
      chk("mode_cyc", mode_cyc, 21);
      chk("cmd_bad", cmd_bad, 0);
      chk("hold_bad", hold_bad, 0);
      chk("excl_bad", excl_bad, 0);
      chk("m_left", 32'(exp_m.size()), 0);
      chk("wr_left", 32'(exp_wr.size()), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      exp_wr.delete(); exp_m.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      rst = 1'b0; start = 1'b1; op = 3'd3; n_words = 10'd4; s_valid = 1'b0; s_data = 8'd0;
      // reset held with start asserted
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ctrl", {19'd0, s_ready, m_valid, done, err, ap_write_en, ap_read_en, ap_mode, ap_cmd, ap_sel_col}, 0);
      chk("rst_data", {6'd0, m_data, ap_addr, ap_data}, 0);
      @(posedge clk); #1; start = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("post_rst_ctrl", {19'd0, s_ready, m_valid, done, err, ap_write_en, ap_read_en, ap_mode, ap_cmd, ap_sel_col}, 0);
      chk("post_rst_busy", {31'd0, busy}, 0);
      @(posedge clk); #1;

      // basic job
      wa = '{8'd1, 8'd2, 8'd3, 8'd4}; wb = '{8'd5, 8'd6, 8'd7, 8'd8};
      launch_job(3'd3, 4, 0, -1, 1'b1);
      wait_done(400);
      job_checks(4);

      // backpressure on both streams, wrapping sums
      wa = '{8'hF0, 8'h11, 8'h7F, 8'h80}; wb = '{8'h20, 8'hEF, 8'h01, 8'h80};
      bp_mode = 1'b1;
      launch_job(3'd3, 4, 2, -1, 1'b1);
      wait_done(600);
      bp_mode = 1'b0;
      job_checks(4);

      // start pulse during LOAD_B is ignored
      wa = '{8'd9, 8'd10, 8'd11, 8'd0}; wb = '{8'd100, 8'd150, 8'd200, 8'd0};
      launch_job(3'd3, 3, 0, 1, 1'b1);
      wait_done(400);
      job_checks(3);

      // empty job
      clear_counts();
      op = 3'd3; n_words = 10'd0; start = 1'b1;
      @(negedge clk);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("empty_busy", {31'd0, busy}, 1);
      chk("empty_done0", {31'd0, done}, 0);
      @(negedge clk);
      chk("empty_busy_end", {31'd0, busy}, 0);
      chk("empty_done", {31'd0, done}, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("empty_wr", wr_cnt, 0);
      chk("empty_rd", rd_cnt, 0);
      chk("empty_mode", mode_cyc, 0);
      chk("empty_done_cnt", done_cnt, 1);

      // timeout on the TIMEOUT=16 instance
      do_reset();
      irq_en = 1'b0;
      wa = '{8'd1, 8'd2, 8'd0, 8'd0}; wb = '{8'd3, 8'd4, 8'd0, 8'd0};
      launch_job(3'd5, 2, 0, -1, 1'b0);
      c = 0;
      while (t_done_cnt == 0 && c < 300) begin @(posedge clk); c++; end
      chk("t_done_seen", (t_done_cnt != 0) ? 32'd1 : 32'd0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t_err", {31'd0, t_err}, 1);
      chk("t_done_cnt", t_done_cnt, 1);
      chk("t_mode_cyc", t_mode_cyc, 16);
      chk("t_rd_cnt", t_rd_cnt, 0);
      chk("t_busy", {31'd0, t_busy}, 0);
      start = 1'b1; n_words = 10'd0;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("t_err_clear", {31'd0, t_err}, 0);
      @(posedge clk); #1;
      do_reset();
      irq_en = 1'b1;

      // abort during RUN, then a fresh job
      wa = '{8'd20, 8'd30, 8'd0, 8'd0}; wb = '{8'd1, 8'd2, 8'd0, 8'd0};
      launch_job(3'd3, 2, 0, -1, 1'b1);
      c = 0;
      while (!ap_mode && c < 100) begin @(posedge clk); #1; c++; end
      chk("abort_in_run", {31'd0, ap_mode}, 1);
      #2; rst = 1'b0; #1;
      chk("abort_mode", {31'd0, ap_mode}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      repeat (3) @(posedge clk);
      #1; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      exp_wr.delete(); exp_m.delete();
      wa = '{8'd40, 8'd50, 8'd0, 8'd0}; wb = '{8'd2, 8'd3, 8'd0, 8'd0};
      launch_job(3'd3, 2, 0, -1, 1'b1);
      wait_done(400);
      job_checks(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
